instr_fetch_sequencer: RTL

- Produces the IR word and the HLT flag that the instruction decoder/controller consumes.
- Owns the PC and issues a request/acknowledge fetch to instruction memory.
- Latches the returned word into IR and presents it for exactly one execute slot.
- Applies the branch redirect returned by the datapath; detects the halt instruction and parks the core until RESUME.

---
 rtl/instr_fetch_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches one word at a time from
// instruction memory over a request/acknowledge handshake, presents it in IR
// for a single execute slot, applies branch redirects and parks on halt.
module instr_fetch_sequencer #(
  parameter int              AW        = 10,
  parameter int              IW        = 16,
  parameter logic [AW-1:0]   RESET_PC  = '0,
  parameter logic [5:0]      HALT_FUNC = 6'b111111
) (
  input  logic          clk,
  input  logic          rst,
  output logic          IMEM_REQ,
  output logic [AW-1:0] IMEM_ADDR,
  input  logic          IMEM_ACK,
  input  logic [IW-1:0] IMEM_DATA,
  output logic [IW-1:0] IR,
  output logic          IR_VALID,
  output logic          HLT,
  input  logic          STALL,
  input  logic          BR_TAKEN,
  input  logic [AW-1:0] BR_TARGET,
  input  logic          RESUME,
  output logic [AW-1:0] PC,
  output logic [AW-1:0] PC_LINK
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [IW-1:0] ir_q;
  logic          irValid_q;
  logic          hlt_q;
  logic          imemReq_q;

  logic [AW-1:0] pcInc_d;
  logic [AW-1:0] retirePc_d;
  logic          isHalt_d;

  // Sequential-PC and redirect targets, plus halt-word decode of the returning fetch.
  always_comb begin
    pcInc_d    = pc_q + AW'(1);
    retirePc_d = BR_TAKEN ? BR_TARGET : pcInc_d;
    isHalt_d   = (IMEM_DATA[5:0] == HALT_FUNC);
  end

  // Fetch/execute/halt control; every consumer-facing output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      irValid_q <= 1'b0;
      hlt_q     <= 1'b0;
      imemReq_q <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (!imemReq_q) begin
            // First cycle out of reset: raise the request, nothing is outstanding yet.
            imemReq_q <= 1'b1;
          end else if (IMEM_ACK) begin
            ir_q      <= IMEM_DATA;
            imemReq_q <= 1'b0;
            if (isHalt_d) begin
              state_q <= HALTED;
              hlt_q   <= 1'b1;
            end else begin
              state_q   <= EXEC;
              irValid_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (!STALL) begin
            irValid_q <= 1'b0;
            pc_q      <= retirePc_d;
            state_q   <= FETCH;
            imemReq_q <= 1'b1;
          end
        end
        HALTED: begin
          if (RESUME) begin
            hlt_q     <= 1'b0;
            pc_q      <= pcInc_d;
            state_q   <= FETCH;
            imemReq_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= FETCH;
          irValid_q <= 1'b0;
          hlt_q     <= 1'b0;
          imemReq_q <= 1'b0;
        end
      endcase
    end
  end

  // Address and link value follow the PC register directly.
  always_comb begin
    IMEM_ADDR = pc_q;
    PC_LINK   = pcInc_d;
  end

  assign IMEM_REQ = imemReq_q;
  assign IR       = ir_q;
  assign IR_VALID = irValid_q;
  assign HLT      = hlt_q;
  assign PC       = pc_q;

endmodule
